// File: rtl/bird_physics.sv
// bird_physics: tick-driven bird position/velocity with gravity, flap, bounds and collision; BIRD_INVINCIBLE_EN disables death
module bird_physics #(
    parameter int Y_MAX      = 15,
    parameter int Y_START    = 8,
    parameter int FLAP_VEL   = 2,
    parameter int GRAVITY    = 1,
    parameter int VMAX_DOWN  = 3,
    parameter int VEL_WIDTH  = 4,
    parameter int HOLD_TICKS = 4,
    localparam int YW = $clog2(Y_MAX + 1)
) (
    input  logic                        clock_in,
    input  logic                        reset,
    input  logic                        tick_clk,
    input  logic                        flap_key,
    input  logic                        collide,
    output logic [YW-1:0]               bird_y,
    output logic signed [VEL_WIDTH-1:0] bird_vel,
    output logic [1:0]                  state,
    output logic                        game_over,
    output logic                        tick_out
);
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] FLYING = 2'b01;
    localparam logic [1:0] DEAD   = 2'b10;
    localparam int CW = $clog2(HOLD_TICKS + 1);
    localparam logic [CW-1:0] HT = CW'(HOLD_TICKS);
    localparam logic [YW-1:0] YS = YW'(Y_START);
    localparam logic [YW-1:0] YM = YW'(Y_MAX);
    localparam logic signed [YW+1:0] YM_S = (YW+2)'(Y_MAX);
    localparam logic signed [VEL_WIDTH-1:0] FV = VEL_WIDTH'(FLAP_VEL);
    localparam logic signed [VEL_WIDTH:0] GRV = (VEL_WIDTH+1)'(GRAVITY);
    localparam logic signed [VEL_WIDTH:0] VMIN = (VEL_WIDTH+1)'(-VMAX_DOWN);
`ifdef BIRD_INVINCIBLE_EN
    localparam logic MORTAL = 1'b0;
`else
    localparam logic MORTAL = 1'b1;
`endif

    logic q1, q2, f1, f2, f3, flap_pending;
    logic [CW-1:0] hold_cnt;
    logic tick, flap_edge, pend, floor_hit, ceil_hit;
    logic signed [VEL_WIDTH-1:0] vel_eff, nv;
    logic signed [VEL_WIDTH:0] vm;
    logic signed [YW+1:0] ny;

    assign tick      = q1 & ~q2;
    assign flap_edge = f2 & ~f3;
    assign pend      = flap_pending | flap_edge;
    assign game_over = state == DEAD;

    // next position/velocity for a FLYING tick, with a same-cycle flap edge folded in
    always_comb begin
        vel_eff   = pend ? FV : bird_vel;
        ny        = signed'({2'b00, bird_y}) + (YW+2)'(vel_eff);
        vm        = (VEL_WIDTH+1)'(vel_eff) - GRV;
        nv        = vm < VMIN ? VMIN[VEL_WIDTH-1:0] : vm[VEL_WIDTH-1:0];
        floor_hit = ny[YW+1];
        ceil_hit  = !floor_hit && ny > YM_S;
    end

    // edge detectors, game FSM and bird state
    always_ff @(posedge clock_in) begin
        if (reset) begin
            {q1, q2, f1, f2, f3} <= '0;
            tick_out     <= 1'b0;
            bird_y       <= YS;
            bird_vel     <= '0;
            state        <= IDLE;
            flap_pending <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            q1       <= tick_clk;
            q2       <= q1;
            f1       <= flap_key;
            f2       <= f1;
            f3       <= f2;
            tick_out <= tick;
            case (state)
                IDLE: begin
                    flap_pending <= pend;
                    if (pend) state <= FLYING;
                end
                FLYING: begin
                    if (collide && MORTAL) begin
                        state        <= DEAD;
                        flap_pending <= 1'b0;
                    end else if (tick) begin
                        flap_pending <= 1'b0;
                        bird_y       <= floor_hit ? '0 : ceil_hit ? YM : ny[YW-1:0];
                        bird_vel     <= (floor_hit || ceil_hit) ? '0 : nv;
                        if (floor_hit && MORTAL) state <= DEAD;
                    end else begin
                        flap_pending <= pend;
                    end
                end
                DEAD: begin
                    flap_pending <= 1'b0;
                    if (flap_edge && hold_cnt == HT) begin
                        state    <= IDLE;
                        bird_y   <= YS;
                        bird_vel <= '0;
                        hold_cnt <= '0;
                    end else if (tick && hold_cnt != HT) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bird_physics.sv
// tb_bird_physics: directed vectors for bird_physics (honours BIRD_INVINCIBLE_EN)
module tb_bird_physics;
    logic clock_in = 1'b0;
    logic reset = 1'b1, tick_clk = 1'b0, flap_key = 1'b0, collide = 1'b0;
    logic [3:0] bird_y;
    logic signed [3:0] bird_vel;
    logic [1:0] state;
    logic game_over, tick_out;
    int vectors = 0, miscompares = 0;

    always #5 clock_in = ~clock_in;

    bird_physics dut (
        .clock_in(clock_in), .reset(reset), .tick_clk(tick_clk), .flap_key(flap_key),
        .collide(collide), .bird_y(bird_y), .bird_vel(bird_vel), .state(state),
        .game_over(game_over), .tick_out(tick_out)
    );

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    task automatic do_tick;
        tick_clk = 1'b1;
        step(2);
        tick_clk = 1'b0;
        step(2);
    endtask

    task automatic do_flap;
        flap_key = 1'b1;
        step(4);
        flap_key = 1'b0;
        step(3);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic check_yv(input string tag, input int y, input int v);
        check({tag, ".y"}, bird_y, y);
        check({tag, ".v"}, bird_vel, v);
    endtask

    initial begin
        int ey[8] = '{10, 11, 11, 10, 8, 5, 2, 0};
        int ev[8] = '{1, 0, -1, -2, -3, -3, -3, 0};
        int pulses = 0;
        step(2);
        reset = 1'b0;
        step(1);
        check_yv("rst", 8, 0);
        check("rst.state", state, 0);
        check("rst.go", game_over, 0);
        check("rst.tick", tick_out, 0);

        tick_clk = 1'b1;
        step(1);
        check("tick.e0", tick_out, 0);
        step(1);
        check("tick.e1", tick_out, 1);
        step(1);
        check("tick.e2", tick_out, 0);
        repeat (100) begin
            step(1);
            pulses += int'(tick_out);
        end
        check("tick.held", pulses, 0);
        tick_clk = 1'b0;
        step(2);
        check("idle.y", bird_y, 8);
        check("idle.state", state, 0);

        do_flap;
        check("fly.state", state, 1);
        for (int i = 0; i < 8; i++) begin
            do_tick;
            check_yv($sformatf("fall%0d", i), ey[i], ev[i]);
        end
`ifdef BIRD_INVINCIBLE_EN
        check("floor.state", state, 1);
        check("floor.go", game_over, 0);
`else
        check("floor.state", state, 2);
        check("floor.go", game_over, 1);
`endif

        do_reset;
        do_flap;
        do_tick;
        do_tick;
        do_flap;
        do_tick;
        do_tick;
        check_yv("pre_ceil", 14, 0);
        flap_key = 1'b1;
        step(1);
        tick_clk = 1'b1;
        step(2);
        flap_key = 1'b0;
        tick_clk = 1'b0;
        step(3);
        check_yv("ceil", 15, 0);
        check("ceil.state", state, 1);
        do_tick;
        check_yv("ceil_next", 15, -1);

        do_reset;
        do_flap;
        do_tick;
        collide = 1'b1;
        step(1);
        collide = 1'b0;
`ifdef BIRD_INVINCIBLE_EN
        check("coll.state", state, 1);
        check_yv("coll", 10, 1);
`else
        check("coll.state", state, 2);
        check("coll.go", game_over, 1);
        check_yv("coll", 10, 1);
        do_tick;
        do_tick;
        do_flap;
        check("early_flap.state", state, 2);
        check_yv("dead_frozen", 10, 1);
        do_tick;
        do_tick;
        do_flap;
        check("rearm.state", state, 0);
        check("rearm.go", game_over, 0);
        check_yv("rearm", 8, 0);
        do_tick;
        check("rearm.idle", state, 0);
`endif

        do_reset;
        flap_key = 1'b1;
        step(4);
        check("held.state", state, 1);
        for (int i = 0; i < 5; i++) begin
            do_tick;
            check_yv($sformatf("held%0d", i), ey[i], ev[i]);
        end
        flap_key = 1'b0;

        do_reset;
        do_flap;
        do_tick;
        do_tick;
        check("pre_rst.y", bird_y, 11);
        reset = 1'b1;
        step(1);
        check_yv("mid_rst", 8, 0);
        check("mid_rst.state", state, 0);
        reset = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
